// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port used by the fetch stage.
// The master side issues requests; the slave side returns instructions with a ready strobe.
interface fetch_stage_if #(
    parameter int ADDRESS_LEN     = 32,
    parameter int INSTRUCTION_LEN = 32
);
    logic                       imem_req;
    logic [ADDRESS_LEN-1:0]     imem_addr;
    logic [INSTRUCTION_LEN-1:0] imem_rdata;
    logic                       imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction-memory port and the IF/ID register.
// Handles decode stalls with a one-entry skid and branch redirects, including one with a fetch in flight.
module fetch_stage #(
    parameter int                     ADDRESS_LEN     = 32,
    parameter int                     INSTRUCTION_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [ADDRESS_LEN-1:0]     branch_address,
    fetch_stage_if.master              imem,
    output logic [ADDRESS_LEN-1:0]     pc_out,
    output logic [INSTRUCTION_LEN-1:0] instruction_out,
    output logic                       valid_out
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    localparam logic [ADDRESS_LEN-1:0] PC_STEP = ADDRESS_LEN'(32'd4);

    state_t                     state_r;
    logic [ADDRESS_LEN-1:0]     fetch_pc_r;
    logic [ADDRESS_LEN-1:0]     redirect_pc_r;
    logic [ADDRESS_LEN-1:0]     skid_pc_r;
    logic [INSTRUCTION_LEN-1:0] skid_instr_r;
    logic [ADDRESS_LEN-1:0]     fetch_pc_next_s;

    assign fetch_pc_next_s = fetch_pc_r + PC_STEP;

    // Request decode: only registered state and reset; DROP re-presents the abandoned address held in fetch_pc_r.
    always_comb begin
        imem.imem_req = 1'b0;
        if (rst) begin
            imem.imem_req = 1'b0;
        end else begin
            imem.imem_req = (state_r != ST_HOLD);
        end
    end

    assign imem.imem_addr = fetch_pc_r;

    // Fetch FSM together with the PC, skid, redirect target and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_FETCH;
            fetch_pc_r      <= RESET_PC;
            redirect_pc_r   <= '0;
            skid_pc_r       <= '0;
            skid_instr_r    <= '0;
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (branch_taken) begin
                        pc_out          <= '0;
                        instruction_out <= '0;
                        valid_out       <= 1'b0;
                        if (imem.imem_ready) begin
                            fetch_pc_r <= branch_address;
                        end else begin
                            // The request in flight cannot be withdrawn; wait it out in DROP.
                            redirect_pc_r <= branch_address;
                            state_r       <= ST_DROP;
                        end
                    end else if (imem.imem_ready) begin
                        fetch_pc_r <= fetch_pc_next_s;
                        if (freeze) begin
                            skid_pc_r    <= fetch_pc_r;
                            skid_instr_r <= imem.imem_rdata;
                            state_r      <= ST_HOLD;
                        end else begin
                            pc_out          <= fetch_pc_next_s;
                            instruction_out <= imem.imem_rdata;
                            valid_out       <= 1'b1;
                        end
                    end else if (!freeze) begin
                        pc_out          <= '0;
                        instruction_out <= '0;
                        valid_out       <= 1'b0;
                    end else begin
                        valid_out <= valid_out;
                    end
                end
                ST_HOLD: begin
                    if (branch_taken) begin
                        pc_out          <= '0;
                        instruction_out <= '0;
                        valid_out       <= 1'b0;
                        skid_pc_r       <= '0;
                        skid_instr_r    <= '0;
                        fetch_pc_r      <= branch_address;
                        state_r         <= ST_FETCH;
                    end else if (!freeze) begin
                        pc_out          <= skid_pc_r + PC_STEP;
                        instruction_out <= skid_instr_r;
                        valid_out       <= 1'b1;
                        state_r         <= ST_FETCH;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (branch_taken) begin
                        pc_out          <= '0;
                        instruction_out <= '0;
                        valid_out       <= 1'b0;
                        redirect_pc_r   <= branch_address;
                        if (imem.imem_ready) begin
                            fetch_pc_r <= branch_address;
                            state_r    <= ST_FETCH;
                        end else begin
                            state_r <= ST_DROP;
                        end
                    end else begin
                        if (!freeze) begin
                            pc_out          <= '0;
                            instruction_out <= '0;
                            valid_out       <= 1'b0;
                        end else begin
                            valid_out <= valid_out;
                        end
                        if (imem.imem_ready) begin
                            fetch_pc_r <= redirect_pc_r;
                            state_r    <= ST_FETCH;
                        end else begin
                            state_r <= ST_DROP;
                        end
                    end
                end
                default: begin
                    state_r         <= ST_FETCH;
                    pc_out          <= '0;
                    instruction_out <= '0;
                    valid_out       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, freeze/skid, branch during wait, branch in HOLD,
// double redirect during DROP, reset mid-wait and PC wrap on a second instance.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_w = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = 32'h0;
    logic [31:0] pc_out, instruction_out, pc_out_w, instruction_out_w;
    logic        valid_out, valid_out_w;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I0 = 32'hE3A00001;
    localparam logic [31:0] I1 = 32'hE3A00002;
    localparam logic [31:0] I2 = 32'hE3A00003;
    localparam logic [31:0] IF = 32'hE2811001;
    localparam logic [31:0] I3 = 32'hE0812003;
    localparam logic [31:0] I4 = 32'hE0812004;
    localparam logic [31:0] I5 = 32'hE0812005;
    localparam logic [31:0] I6 = 32'hE0812006;
    localparam logic [31:0] I7 = 32'hE0812007;

    fetch_stage_if #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32)) if_a ();
    fetch_stage_if #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32)) if_w ();

    fetch_stage #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32), .RESET_PC(32'h00000100)) u_dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem(if_a), .pc_out(pc_out),
        .instruction_out(instruction_out), .valid_out(valid_out)
    );

    fetch_stage #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32), .RESET_PC(32'hFFFFFFFC)) u_dut_w (
        .clk(clk), .rst(rst_w), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem(if_w), .pc_out(pc_out_w),
        .instruction_out(instruction_out_w), .valid_out(valid_out_w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic v);
        check({tag, ".pc"}, pc_out, pc);
        check({tag, ".instr"}, instruction_out, ins);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    endtask

    initial begin
        if_a.imem_ready = 1'b0;
        if_a.imem_rdata = 32'h0;
        if_w.imem_ready = 1'b0;
        if_w.imem_rdata = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_req", {31'd0, if_a.imem_req}, 32'd0);
        check_ifid("rst_ifid", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("first_req", {31'd0, if_a.imem_req}, 32'd1);
        check("first_addr", if_a.imem_addr, 32'h100);

        // Zero-wait streaming
        if_a.imem_ready = 1'b1;
        if_a.imem_rdata = I0;
        tick();
        check_ifid("s0", 32'h104, I0, 1'b1);
        check("s0_addr", if_a.imem_addr, 32'h104);
        if_a.imem_rdata = I1;
        tick();
        check_ifid("s1", 32'h108, I1, 1'b1);
        if_a.imem_rdata = I2;
        tick();
        check_ifid("s2", 32'h10C, I2, 1'b1);
        check("s2_addr", if_a.imem_addr, 32'h10C);

        // Freeze on a response: three held cycles, then skid drains
        freeze = 1'b1;
        if_a.imem_rdata = IF;
        tick();
        check_ifid("fz1", 32'h10C, I2, 1'b1);
        check("fz1_req", {31'd0, if_a.imem_req}, 32'd0);
        if_a.imem_ready = 1'b0;
        tick();
        check_ifid("fz2", 32'h10C, I2, 1'b1);
        tick();
        check_ifid("fz3", 32'h10C, I2, 1'b1);
        check("fz3_req", {31'd0, if_a.imem_req}, 32'd0);
        freeze = 1'b0;
        tick();
        check_ifid("fz_out", 32'h110, IF, 1'b1);
        check("fz_out_req", {31'd0, if_a.imem_req}, 32'd1);
        check("fz_out_addr", if_a.imem_addr, 32'h110);

        // Branch during first wait cycle of a 2-wait fetch
        branch_taken = 1'b1;
        branch_address = 32'h200;
        tick();
        check_ifid("dr1", 32'h0, 32'h0, 1'b0);
        check("dr1_addr", if_a.imem_addr, 32'h110);
        branch_taken = 1'b0;
        branch_address = 32'h0;
        tick();
        check("dr2_addr", if_a.imem_addr, 32'h110);
        check("dr2_req", {31'd0, if_a.imem_req}, 32'd1);
        if_a.imem_ready = 1'b1;
        if_a.imem_rdata = 32'hDEADBEEF;
        tick();
        check_ifid("dr3", 32'h0, 32'h0, 1'b0);
        check("dr3_addr", if_a.imem_addr, 32'h200);
        if_a.imem_rdata = I3;
        tick();
        check_ifid("tgt", 32'h204, I3, 1'b1);

        // Branch together with freeze while in HOLD
        freeze = 1'b1;
        if_a.imem_rdata = I4;
        tick();
        check_ifid("h1", 32'h204, I3, 1'b1);
        check("h1_req", {31'd0, if_a.imem_req}, 32'd0);
        if_a.imem_ready = 1'b0;
        branch_taken = 1'b1;
        branch_address = 32'h200;
        tick();
        check("h2_valid", {31'd0, valid_out}, 32'd0);
        check("h2_addr", if_a.imem_addr, 32'h200);
        check("h2_req", {31'd0, if_a.imem_req}, 32'd1);

        // Two redirects inside one DROP window: newest wins
        freeze = 1'b0;
        branch_address = 32'h300;
        tick();
        check("d1_addr", if_a.imem_addr, 32'h200);
        branch_address = 32'h400;
        tick();
        check("d2_addr", if_a.imem_addr, 32'h200);
        branch_taken = 1'b0;
        branch_address = 32'h0;
        if_a.imem_ready = 1'b1;
        if_a.imem_rdata = 32'hBADC0DE0;
        tick();
        check_ifid("d3", 32'h0, 32'h0, 1'b0);
        check("d3_addr", if_a.imem_addr, 32'h400);
        if_a.imem_rdata = I5;
        tick();
        check_ifid("d4", 32'h404, I5, 1'b1);

        // Wait cycle gives a bubble
        if_a.imem_ready = 1'b0;
        tick();
        check_ifid("bub", 32'h0, 32'h0, 1'b0);
        check("bub_addr", if_a.imem_addr, 32'h404);

        // Reset asserted mid-wait clears everything immediately
        if_a.imem_ready = 1'b1;
        if_a.imem_rdata = I6;
        tick();
        check_ifid("pre_rst", 32'h408, I6, 1'b1);
        if_a.imem_ready = 1'b0;
        freeze = 1'b1;
        tick();
        check("wait_valid", {31'd0, valid_out}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_ifid("mid_rst", 32'h0, 32'h0, 1'b0);
        check("mid_rst_req", {31'd0, if_a.imem_req}, 32'd0);
        freeze = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("restart_addr", if_a.imem_addr, 32'h100);
        check("restart_req", {31'd0, if_a.imem_req}, 32'd1);

        // Second instance: RESET_PC at the top of the address space wraps
        rst_w = 1'b0;
        #1;
        check("w_addr", if_w.imem_addr, 32'hFFFFFFFC);
        if_w.imem_ready = 1'b1;
        if_w.imem_rdata = I7;
        tick();
        check("w_pc", pc_out_w, 32'h0);
        check("w_instr", instruction_out_w, I7);
        check("w_valid", {31'd0, valid_out_w}, 32'd1);
        check("w_next_addr", if_w.imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage ARM pipeline: owns the fetch PC, drives a ready-handshaked instruction-memory port, and holds the IF/ID pipeline register feeding decode. It is the direct consumer of the hazard unit's stall output, `freeze`. On `freeze` it holds IF/ID and parks any instruction already returned. On a taken branch from EXE it redirects the PC and flushes wrong-path instructions, including a fetch still in flight.

## Interface
- `ADDRESS_LEN`, 32, width of PC and memory address.
- `INSTRUCTION_LEN`, 32, instruction width.
- `RESET_PC`, 0, fetch address after reset.

- `clk` input 1, the single clock; all state updates on rising edge.
- `rst` input 1, asynchronous, active-high reset.
- `freeze` input 1, stall from the hazard detection unit; decode is holding its instruction.
- `branch_taken` input 1, redirect request from EXE, one-cycle pulse.
- `branch_address` input `ADDRESS_LEN`, redirect target; sampled only when `branch_taken`=1.
- `imem_req` output 1, fetch request.
- `imem_addr` output `ADDRESS_LEN`, fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_rdata` input `INSTRUCTION_LEN`, instruction; valid only in a cycle with `imem_req`=1 and `imem_ready`=1.
- `imem_ready` input 1, response strobe; may come in the request cycle (zero wait) or any later cycle.
- `pc_out` output `ADDRESS_LEN`, IF/ID register: fetched address + 4.
- `instruction_out` output `INSTRUCTION_LEN`, IF/ID register: instruction.
- `valid_out` output 1, IF/ID register: 1 = real instruction, 0 = bubble.

## Operation
- Registers:
  - `fetch_pc`: address of the current or next request.
  - Skid buffer: instruction + address.
  - `redirect_pc`.
  - 2-bit state: FETCH, HOLD, DROP.
  - The IF/ID register.
- FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`. A response is a cycle with `imem_ready`=1.
  - Response, `freeze`=0: IF/ID loads {`fetch_pc`+4, `imem_rdata`, valid=1}; `fetch_pc` += 4; stay in FETCH.
  - Response, `freeze`=1: IF/ID holds. Skid captures {`fetch_pc`, `imem_rdata`}; `fetch_pc` += 4; go to HOLD.
  - No response: `freeze`=1 holds IF/ID; `freeze`=0 loads a bubble (valid=0, instruction 0, pc 0).
- HOLD: `imem_req`=0; IF/ID holds while `freeze`=1. When `freeze`=0, IF/ID loads the skid contents with valid=1, then go to FETCH.
- DROP: `imem_req`=1, `imem_addr` = address of the abandoned request. IF/ID loads a bubble unless `freeze`=1. On `imem_ready`: discard `imem_rdata`; `fetch_pc` <= `redirect_pc`; go to FETCH.
- `branch_taken` has priority over `freeze` and over any response in the same cycle:
  - IF/ID is flushed to a bubble; the branching instruction is in EXE, so decode holds wrong-path work.
  - FETCH, `imem_ready`=1 that cycle: response discarded; `fetch_pc` <= `branch_address`; stay in FETCH.
  - FETCH, `imem_ready`=0: request must not be abandoned. `redirect_pc` <= `branch_address`; go to DROP.
  - HOLD: skid discarded; `fetch_pc` <= `branch_address`; go to FETCH.
  - DROP: `redirect_pc` <= `branch_address` (newest target wins). If `imem_ready`=1 that cycle, `fetch_pc` <= `branch_address` directly; go to FETCH.
- Arithmetic: PC increment is +4 modulo 2^`ADDRESS_LEN`. 0xFFFFFFFC wraps to 0x00000000 with no flag.

## Timing
- Reset (async, immediate):
  - state FETCH, `fetch_pc` = `RESET_PC`.
  - `pc_out`=0, `instruction_out`=0, `valid_out`=0.
  - Skid and `redirect_pc` cleared.
  - `imem_req`=0 while `rst`=1; `imem_req`=1 from the first cycle after release.
- Reset mid-fetch drops the outstanding request with no drain. Memory must tolerate abandonment on reset only.
- `imem_req`/`imem_addr` are decoded from registered state only, with no combinational path from `imem_ready`, `freeze` or `branch_taken`.
- Latency:
  - Zero-wait memory: instruction at `fetch_pc` appears on IF/ID the edge after its response; throughput is 1 instruction/cycle.
  - N wait cycles: N bubbles.
- After a branch, the target's request is issued the next cycle (FETCH case) or the cycle after the stale response (DROP case).
- HOLD exit: the skid instruction is visible on IF/ID the edge after `freeze` falls; the next request issues in that same following cycle.

## Test plan
- Zero-wait memory, `RESET_PC`=0x100, no freeze: `valid_out` rises 1 cycle after the first request. `pc_out` sequence 0x104, 0x108, 0x10C…, one per cycle, with matching instructions.
- `freeze` high 3 cycles on a response cycle returning 0xE2811001: IF/ID holds the prior instruction 3 cycles. `imem_req`=0 during HOLD. 0xE2811001 appears the edge after `freeze` drops, then fetch resumes at +4.
- Memory with 2 wait cycles; `branch_taken` to 0x200 in the first wait cycle: `imem_addr` held at the old address until ready. Stale response discarded, `valid_out`=0. Next request address 0x200.
- `branch_taken` and `freeze` asserted together in HOLD: skid discarded; `valid_out`=0 next edge; next `imem_addr`=0x200.
- Two branches (0x300, then 0x400) during one DROP: fetch resumes at 0x400 only.
- `RESET_PC`=0xFFFFFFFC: `pc_out`=0x00000000 for the first instruction. Asserting `rst` mid-wait clears all outputs in the same cycle, and fetch restarts at `RESET_PC`.
